serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/fsub_cell.sv | 13 +
 rtl/serial_subtractor.sv | 104 ++++++++++
 tb/tb_serial_subtractor.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: default width and FSM state encoding.
package serial_sub_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, borrow
  );

endinterface

// File: rtl/fsub_cell.sv
// One-bit full subtractor: diff = a - b - c, borrow set when the bit underflows.
module fsub_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b ^ c;
  assign borrow = (~a & b) | (~a & c) | (b & c);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB first, one bit per clock, WIDTH+2 cycles per op.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sr_q, a_sr_d;
  logic [WIDTH-1:0]  b_sr_q, b_sr_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              borrow_ff_q, borrow_ff_d;
  logic              borrow_q, borrow_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              step_diff;
  logic              step_borrow;

  fsub_cell u_fsub_cell (
    .a      (a_sr_q[0]),
    .b      (b_sr_q[0]),
    .c      (borrow_ff_q),
    .diff   (step_diff),
    .borrow (step_borrow)
  );

  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    res_d       = res_q;
    diff_d      = diff_q;
    borrow_ff_d = borrow_ff_q;
    borrow_d    = borrow_q;
    cnt_d       = cnt_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_sr_d      = bus.a;
          b_sr_d      = bus.b;
          borrow_ff_d = bus.bin;
          cnt_d       = '0;
          state_d     = StShift;
        end
      end
      StShift: begin
        a_sr_d      = a_sr_q >> 1;
        b_sr_d      = b_sr_q >> 1;
        res_d       = {step_diff, res_q[WIDTH-1:1]};
        borrow_ff_d = step_borrow;
        if (cnt_q == CntLast) begin
          // Counter parks at its last value instead of wrapping; reloaded on next start.
          state_d  = StDone;
          diff_d   = res_d;
          borrow_d = step_borrow;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      res_q       <= '0;
      diff_q      <= '0;
      borrow_ff_q <= 1'b0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      res_q       <= res_d;
      diff_q      <= diff_d;
      borrow_ff_q <= borrow_ff_d;
      borrow_q    <= borrow_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.busy   = (state_q != StIdle);
  assign bus.done   = (state_q == StDone);
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized self-checking bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus ();

  serial_subtractor #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one op and follows it until busy drops; lat = edges after the accepting edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output logic [7:0] d, output logic br, output int lat,
                        output int busy_cnt);
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    d         = 'x;
    br        = 1'bx;
    lat       = -1;
    busy_cnt  = 0;
    if (bus.busy) busy_cnt++;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (bus.done && lat < 0) begin
        lat = i;
        d   = bus.diff;
        br  = bus.borrow;
      end
      if (bus.busy) busy_cnt++;
      else break;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b1;
    bus.a     = 8'hAA;
    bus.b     = 8'h55;
    bus.bin   = 1'b1;
    rst       = 1'b1;
    step();
    step();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_priority_busy got=%b exp=0", bus.busy);
    end
    bus.start = 1'b0;
    step();
    rst = 1'b0;
    checks++;
    if (bus.diff !== 8'h00) begin
      failures++;
      $display("FAIL reset_diff got=%h exp=00", bus.diff);
    end
    checks++;
    if (bus.borrow !== 1'b0) begin
      failures++;
      $display("FAIL reset_borrow got=%b exp=0", bus.borrow);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done got=%b exp=0", bus.done);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_busy got=%b exp=0", bus.busy);
    end
  endtask

  task automatic test_basic();
    logic [7:0] d;
    logic       br;
    int         lat, bc;
    run_op(8'h5A, 8'h23, 1'b0, d, br, lat, bc);
    checks++;
    if (d !== 8'h37) begin
      failures++;
      $display("FAIL basic_diff got=%h exp=37", d);
    end
    checks++;
    if (br !== 1'b0) begin
      failures++;
      $display("FAIL basic_borrow got=%b exp=0", br);
    end
    checks++;
    if (lat !== 8) begin
      failures++;
      $display("FAIL basic_latency got=%0d exp=8", lat);
    end
    step();
    step();
    checks++;
    if (bus.diff !== 8'h37 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL basic_hold got diff=%h done=%b exp diff=37 done=0", bus.diff, bus.done);
    end
  endtask

  task automatic test_borrow_cases();
    logic [7:0] d;
    logic       br;
    int         lat, bc;
    run_op(8'h00, 8'h01, 1'b0, d, br, lat, bc);
    checks++;
    if (d !== 8'hFF || br !== 1'b1) begin
      failures++;
      $display("FAIL underflow1 got diff=%h borrow=%b exp diff=ff borrow=1", d, br);
    end
    run_op(8'h00, 8'hFF, 1'b1, d, br, lat, bc);
    checks++;
    if (d !== 8'h00 || br !== 1'b1) begin
      failures++;
      $display("FAIL underflow_bin got diff=%h borrow=%b exp diff=00 borrow=1", d, br);
    end
    run_op(8'hFF, 8'h0F, 1'b1, d, br, lat, bc);
    checks++;
    if (d !== 8'hEF || br !== 1'b0) begin
      failures++;
      $display("FAIL no_borrow got diff=%h borrow=%b exp diff=ef borrow=0", d, br);
    end
  endtask

  task automatic test_busy_len();
    logic [7:0] d;
    logic       br;
    int         lat, bc;
    run_op(8'h80, 8'h7F, 1'b1, d, br, lat, bc);
    checks++;
    if (d !== 8'h00 || br !== 1'b0) begin
      failures++;
      $display("FAIL exact_zero got diff=%h borrow=%b exp diff=00 borrow=0", d, br);
    end
    checks++;
    if (bc !== 9) begin
      failures++;
      $display("FAIL busy_cycles got=%0d exp=9", bc);
    end
  endtask

  task automatic test_ignore_start();
    int         dones = 0;
    logic [7:0] d     = 'x;
    logic       br    = 1'bx;
    bus.a     = 8'h5A;
    bus.b     = 8'h23;
    bus.bin   = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.done) dones++;
    end
    bus.a     = 8'hFF;
    bus.b     = 8'h11;
    bus.bin   = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        dones++;
        d  = bus.diff;
        br = bus.borrow;
      end
      step();
    end
    checks++;
    if (dones !== 1) begin
      failures++;
      $display("FAIL ignore_done_count got=%0d exp=1", dones);
    end
    checks++;
    if (d !== 8'h37 || br !== 1'b0) begin
      failures++;
      $display("FAIL ignore_result got diff=%h borrow=%b exp diff=37 borrow=0", d, br);
    end
  endtask

  task automatic test_reset_abort();
    int         dones = 0;
    logic [7:0] d;
    logic       br;
    int         lat, bc;
    bus.a     = 8'h33;
    bus.b     = 8'h11;
    bus.bin   = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.diff !== 8'h00 || bus.borrow !== 1'b0) begin
      failures++;
      $display("FAIL abort_state got busy=%b diff=%h borrow=%b exp busy=0 diff=00 borrow=0",
               bus.busy, bus.diff, bus.borrow);
    end
    for (int i = 0; i < 20; i++) begin
      if (bus.done) dones++;
      step();
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL abort_done got=%0d exp=0", dones);
    end
    run_op(8'h10, 8'h01, 1'b0, d, br, lat, bc);
    checks++;
    if (d !== 8'h0F || br !== 1'b0) begin
      failures++;
      $display("FAIL after_abort got diff=%h borrow=%b exp diff=0f borrow=0", d, br);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d_q[$];
    logic       exp_b_q[$];
    logic [7:0] ra, rb, ed;
    logic       rbin, eb;
    int         n_done = 0;
    int         cyc    = 0;
    int         last   = -1;
    ra   = 8'($urandom);
    rb   = 8'($urandom);
    rbin = 1'($urandom);
    bus.a   = ra;
    bus.b   = rb;
    bus.bin = rbin;
    exp_d_q.push_back(ra - rb - {7'd0, rbin});
    exp_b_q.push_back(int'(ra) < int'(rb) + int'(rbin));
    bus.start = 1'b1;
    while (n_done < 2000 && cyc < 25000) begin
      step();
      cyc++;
      if (bus.done) begin
        n_done++;
        ed = 'x;
        eb = 1'bx;
        if (exp_d_q.size() > 0) begin
          ed = exp_d_q.pop_front();
          eb = exp_b_q.pop_front();
        end
        checks++;
        if (bus.diff !== ed || bus.borrow !== eb) begin
          failures++;
          $display("FAIL b2b_result #%0d got diff=%h borrow=%b exp diff=%h borrow=%b",
                   n_done, bus.diff, bus.borrow, ed, eb);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 10) begin
            failures++;
            $display("FAIL b2b_spacing #%0d got=%0d exp=10", n_done, cyc - last);
          end
        end
        last = cyc;
        if (n_done < 2000) begin
          ra   = 8'($urandom);
          rb   = 8'($urandom);
          rbin = 1'($urandom);
          bus.a   = ra;
          bus.b   = rb;
          bus.bin = rbin;
          exp_d_q.push_back(ra - rb - {7'd0, rbin});
          exp_b_q.push_back(int'(ra) < int'(rb) + int'(rbin));
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    checks++;
    if (n_done !== 2000) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=2000", n_done);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    rst       = 1'b1;
    test_reset();
    test_basic();
    test_borrow_cases();
    test_busy_len();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
